nonce_hub: RTL and testbench
============================

# nonce_hub

Multi-slave golden-nonce concentrator between the hashing cores and the UART transmitter. Each slave's nonce reports are queued in a per-slave FIFO rather than a single pending flag, so bursts are held without loss up to DEPTH entries. A fair round-robin arbiter drains the queues one nonce at a time. Each transmitted nonce is tagged with its source slave, and dropped reports are counted.

## Interface
- SLAVES, 2: number of slave cores (≥1)
- NONCE_W, 32: nonce width in bits
- DEPTH, 4: entries per slave FIFO (power of two, ≥2)
- GUARD, 2: minimum cycles spent in WAIT after a send before serial_busy is trusted
- SW = max(1, clog2(SLAVES)): derived slave-index width, not overridable
- uart_clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- new_nonces  in  SLAVES  bit i pulses for one cycle when slave i reports a nonce
- slave_nonces  in  SLAVES*NONCE_W  slice i = bits [i*NONCE_W +: NONCE_W]
- serial_busy  in  1  transmitter busy
- clear_stats  in  1  synchronous clear of overflow and drop_count
- golden_nonce  out  NONCE_W  nonce being sent
- golden_slave  out  SW  source slave of golden_nonce
- serial_send  out  1  one-cycle send strobe
- overflow  out  SLAVES  sticky bit i: slave i lost at least one nonce
- drop_count  out  16  saturating total of dropped nonces

## Operation
- Reset values: golden_nonce=0, golden_slave=0, serial_send=0, overflow=0, drop_count=0, all FIFOs empty, rr_ptr=0, state=IDLE.
- Push: if new_nonces[i]=1, slice i is written to FIFO i on the same edge.
  - The push is accepted if FIFO i is not full, or if FIFO i is popped in the same cycle.
  - Otherwise the nonce is dropped, overflow[i] is set, and drop_count increments. drop_count holds at 16'hFFFF.
  - Multiple drops in one cycle add their total count, saturating.
- clear_stats zeroes overflow and drop_count. A drop in the same cycle wins: the counter loads the number of drops in that cycle, and the matching overflow bits are set.
- State machine:
  - IDLE: if serial_busy=0 and any FIFO is non-empty, the winner is the first non-empty index searching upward from rr_ptr, with wrap-around. The winner is popped, golden_nonce and golden_slave are registered, serial_send goes to 1, rr_ptr becomes (winner+1) mod SLAVES, and the next state is SEND. Otherwise the machine stays in IDLE.
  - SEND: serial_send=0, guard counter is loaded, next state is WAIT.
  - WAIT: the guard counter decrements to 0. Once it is 0 and serial_busy=0, the next state is IDLE.
- golden_nonce and golden_slave hold their values until the next send.
- FIFO order within one slave is strictly first-in, first-out.

## Timing
- Push at edge N: the FIFO is non-empty after N. Earliest serial_send is high for the cycle after edge N+1, i.e. 2-cycle latency from pulse to strobe with an idle transmitter.
- serial_send is exactly 1 cycle wide. golden_nonce and golden_slave are valid in the same cycle and stay stable afterwards.
- Minimum spacing between strobes is 2+GUARD cycles, further extended while serial_busy=1.
- serial_busy is sampled only in IDLE and WAIT, and is never combinationally fed to outputs.
- Reset mid-operation clears serial_send immediately (asynchronous) and discards all queued nonces. The first valid push is the one sampled after reset_n has been high for one edge.

## Structure
- Shared package/include nonce_hub_pkg holds:
  - the state encoding constants IDLE, SEND and WAIT;
  - the clog2 function;
  - the drop_count width constant (16).
- Sub-module nonce_fifo:
  - parameters WIDTH and DEPTH;
  - ports push, push_data, pop, pop_data, empty, full;
  - pointers and occupancy count reset asynchronously.
- The top level instantiates SLAVES nonce_fifo blocks, plus the round-robin arbiter, the state machine and the statistics logic.

## Test plan
- Single nonce 32'hDEADBEEF on slave 1, serial_busy=0 -> serial_send pulses 2 cycles later with golden_nonce=DEADBEEF and golden_slave=1, then no further strobes.
- Both slaves pulse in the same cycle with 32'h11111111 and 32'h22222222, rr_ptr=0 -> slave 0's nonce is sent first, then slave 1's, in order.
- Six pulses on slave 0 while serial_busy=1 (DEPTH=4) -> 4 nonces are queued and sent in FIFO order after busy falls, overflow=2'b01, drop_count=2.
- Continuous traffic on all slaves, SLAVES=4 -> golden_slave sequence is 0,1,2,3,0,...
- With FIFO 0 full, a push and a pop happen in the same cycle -> the push is accepted, with no drop and no overflow.
- reset_n asserted low during WAIT with queued data -> outputs return to reset values. After release with no new pulses, no strobe occurs.

Source files
------------

// File: rtl/nonce_hub_pkg.sv
// ============================================================
// Package : nonce_hub_pkg -- shared FSM encoding, widths and clog2 helper
// Rev     : 1.0
// ============================================================
`default_nettype none

package nonce_hub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int DROP_W = 16;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res++;
            v = v >> 1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nonce_fifo.sv
// ============================================================
// Module : nonce_fifo -- show-ahead FIFO; a push into a full FIFO is taken when a pop coincides
// Rev    : 1.0
// ============================================================
`default_nettype none

module nonce_fifo
    import nonce_hub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/nonce_hub.sv
// ============================================================
// Module : nonce_hub -- per-slave nonce queues drained round-robin into the UART sender
// Rev    : 1.0
// ============================================================
`default_nettype none

module nonce_hub
    import nonce_hub_pkg::*;
#(
    parameter  int SLAVES  = 2,
    parameter  int NONCE_W = 32,
    parameter  int DEPTH   = 4,
    parameter  int GUARD   = 2,
    localparam int SW      = (clog2(SLAVES) > 1) ? clog2(SLAVES) : 1
) (
    input  logic                      uart_clk,
    input  logic                      reset_n,
    input  logic [SLAVES-1:0]         new_nonces,
    input  logic [SLAVES*NONCE_W-1:0] slave_nonces,
    input  logic                      serial_busy,
    input  logic                      clear_stats,
    output logic [NONCE_W-1:0]        golden_nonce,
    output logic [SW-1:0]             golden_slave,
    output logic                      serial_send,
    output logic [SLAVES-1:0]         overflow,
    output logic [DROP_W-1:0]         drop_count
);

    localparam int GW   = (clog2(GUARD + 1) > 1) ? clog2(GUARD + 1) : 1;
    localparam int SUMW = DROP_W + SW + 1;

    state_t              r_state;
    state_t              w_next;
    logic [GW-1:0]       r_guard;
    logic [SW-1:0]       r_rr;
    logic [SW-1:0]       w_winner;
    logic [SW-1:0]       w_idx;
    logic                w_found;
    logic                w_launch;
    logic [SLAVES-1:0]   w_pop;
    logic [SLAVES-1:0]   w_empty;
    logic [SLAVES-1:0]   w_full;
    logic [SLAVES-1:0]   w_drop;
    logic [SUMW-1:0]     w_sum;
    logic [NONCE_W-1:0]  w_fifo_data [SLAVES];

    for (genvar i = 0; i < SLAVES; i++) begin : g_fifo
        nonce_fifo #(
            .WIDTH (NONCE_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (uart_clk),
            .rst_n     (reset_n),
            .push      (new_nonces[i]),
            .push_data (slave_nonces[i*NONCE_W +: NONCE_W]),
            .pop       (w_pop[i]),
            .pop_data  (w_fifo_data[i]),
            .empty     (w_empty[i]),
            .full      (w_full[i])
        );
    end

    // First non-empty queue at or after rr_ptr, wrapping around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < SLAVES; k++) begin
            w_idx = SW'((int'(r_rr) + k) % SLAVES);
            if (!w_found && !w_empty[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_launch = (r_state == IDLE) && !serial_busy && w_found;
    assign w_pop    = w_launch ? (SLAVES'(1) << w_winner) : '0;
    assign w_drop   = new_nonces & w_full & ~w_pop;

    always_ff @(posedge uart_clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // WAIT lasts GUARD cycles at minimum, giving a strobe spacing of 2+GUARD.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_launch) w_next = SEND;
            SEND:    w_next = WAIT;
            WAIT:    if ((r_guard <= GW'(1)) && !serial_busy) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge uart_clk or negedge reset_n) begin
        if (!reset_n) begin
            serial_send  <= 1'b0;
            golden_nonce <= '0;
            golden_slave <= '0;
            r_rr         <= '0;
            r_guard      <= '0;
        end else begin
            serial_send <= w_launch;
            if (w_launch) begin
                golden_nonce <= w_fifo_data[w_winner];
                golden_slave <= w_winner;
                r_rr         <= (w_winner == SW'(SLAVES - 1)) ? '0 : w_winner + SW'(1);
            end
            if (r_state == SEND) begin
                r_guard <= GW'(GUARD);
            end else if ((r_state == WAIT) && (r_guard != '0)) begin
                r_guard <= r_guard - GW'(1);
            end
        end
    end

    always_comb begin
        w_sum = clear_stats ? '0 : SUMW'(drop_count);
        for (int i = 0; i < SLAVES; i++) begin
            w_sum = w_sum + SUMW'(w_drop[i]);
        end
    end

    always_ff @(posedge uart_clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= '0;
            drop_count <= '0;
        end else begin
            overflow   <= (clear_stats ? '0 : overflow) | w_drop;
            drop_count <= (|w_sum[SUMW-1:DROP_W]) ? '1 : w_sum[DROP_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nonce_hub.sv
// ============================================================
// Module : tb_nonce_hub -- scoreboard bench for nonce_hub (4 slaves, depth 4, guard 2)
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_nonce_hub;

    localparam int S = 4;
    localparam int W = 32;
    localparam int D = 4;
    localparam int G = 2;

    typedef struct packed {
        logic [1:0]   slv;
        logic [W-1:0] n;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [S-1:0]   new_nonces;
    logic [S*W-1:0] slave_nonces;
    logic           serial_busy;
    logic           clear_stats;
    logic [W-1:0]   golden_nonce;
    logic [1:0]     golden_slave;
    logic           serial_send;
    logic [S-1:0]   overflow;
    logic [15:0]    drop_count;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   last_t   = -100;
    exp_t sb[$];
    int   st[$];

    nonce_hub #(
        .SLAVES  (S),
        .NONCE_W (W),
        .DEPTH   (D),
        .GUARD   (G)
    ) dut (
        .uart_clk     (clk),
        .reset_n      (reset_n),
        .new_nonces   (new_nonces),
        .slave_nonces (slave_nonces),
        .serial_busy  (serial_busy),
        .clear_stats  (clear_stats),
        .golden_nonce (golden_nonce),
        .golden_slave (golden_slave),
        .serial_send  (serial_send),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Every strobe must match the oldest expected entry and respect the minimum spacing.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset_n) begin
            last_t = -100;
        end else if (serial_send) begin
            if (last_t >= 0) check("spacing_ge_4", 64'((cyc - last_t) >= 2 + G), 64'(1));
            last_t = cyc;
            st.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_strobe", 64'(serial_send), 64'(0));
            end else begin
                e = sb.pop_front();
                check("golden_slave", 64'(golden_slave), 64'(e.slv));
                check("golden_nonce", 64'(golden_nonce), 64'(e.n));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [S-1:0] mask, input logic [S*W-1:0] data, input logic [S-1:0] keep);
        exp_t e;
        new_nonces   = mask;
        slave_nonces = data;
        for (int s = 0; s < S; s++) begin
            if (mask[s] && keep[s]) begin
                e.slv = 2'(s);
                e.n   = data[s*W +: W];
                sb.push_back(e);
            end
        end
        @(negedge clk);
        new_nonces = '0;
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while (sb.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", 64'(sb.size()), 64'(0));
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n     = 1'b0;
        new_nonces  = '0;
        serial_busy = 1'b0;
        clear_stats = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [S*W-1:0] round_data(input int r);
        logic [S*W-1:0] d;
        for (int s = 0; s < S; s++) d[s*W +: W] = 32'h5A00_0000 | (s << 8) | r;
        return d;
    endfunction

    initial begin
        int t;
        reset_n      = 1'b0;
        new_nonces   = '0;
        slave_nonces = '0;
        serial_busy  = 1'b0;
        clear_stats  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_send", 64'(serial_send), 64'(0));
        check("rst_nonce", 64'(golden_nonce), 64'(0));
        check("rst_slave", 64'(golden_slave), 64'(0));
        check("rst_ovf", 64'(overflow), 64'(0));
        check("rst_drops", 64'(drop_count), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Single nonce on slave 1: strobe two edges after the pulse, values then hold.
        new_nonces   = 4'b0010;
        slave_nonces = '0;
        slave_nonces[63:32] = 32'hDEADBEEF;
        sb.push_back('{slv: 2'd1, n: 32'hDEADBEEF});
        @(posedge clk);
        #1;
        new_nonces = '0;
        check("lat_edge_n", 64'(serial_send), 64'(0));
        @(posedge clk);
        #1;
        check("lat_edge_n1", 64'(serial_send), 64'(1));
        drain(50);
        check("hold_nonce", 64'(golden_nonce), 64'(32'hDEADBEEF));
        check("hold_slave", 64'(golden_slave), 64'(1));

        // Simultaneous reports on slaves 0 and 1.
        do_reset();
        drive(4'b0011, {64'h0, 32'h22222222, 32'h11111111}, 4'b0011);
        drain(50);

        // Burst of six on slave 0 while busy; then clear-vs-drop priority.
        do_reset();
        serial_busy = 1'b1;
        for (int k = 0; k < 6; k++)
            drive(4'b0001, {96'h0, 32'(32'hA000_0000 + k)}, (k < 4) ? 4'b0001 : 4'b0000);
        check("burst_ovf", 64'(overflow), 64'(4'b0001));
        check("burst_drops", 64'(drop_count), 64'(2));
        clear_stats = 1'b1;
        drive(4'b0001, {96'h0, 32'h0000_0BAD}, 4'b0000);
        clear_stats = 1'b0;
        check("clr_drop_cnt", 64'(drop_count), 64'(1));
        check("clr_drop_ovf", 64'(overflow), 64'(4'b0001));
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        check("clr_cnt", 64'(drop_count), 64'(0));
        check("clr_ovf", 64'(overflow), 64'(0));
        serial_busy = 1'b0;
        drain(100);

        // Push into full FIFO 0 on the same edge it is popped.
        do_reset();
        serial_busy = 1'b1;
        for (int k = 0; k < 4; k++) drive(4'b0001, {96'h0, 32'(32'hF0 + k)}, 4'b0001);
        serial_busy = 1'b0;
        drive(4'b0001, {96'h0, 32'h0000_00F5}, 4'b0001);
        check("pp_ovf", 64'(overflow), 64'(0));
        check("pp_drops", 64'(drop_count), 64'(0));
        drain(100);

        // Continuous traffic on all slaves: strict rotation at minimum spacing.
        do_reset();
        serial_busy = 1'b1;
        for (int r = 0; r < 4; r++) drive(4'b1111, round_data(r), 4'b1111);
        st.delete();
        serial_busy = 1'b0;
        drain(200);
        check("rr_strobes", 64'(st.size()), 64'(16));
        if (st.size() >= 2) check("rr_span", 64'(st[st.size()-1] - st[0]), 64'(15 * (2 + G)));

        // Saturating drop counter.
        do_reset();
        serial_busy = 1'b1;
        for (int r = 0; r < 4; r++) drive(4'b1111, round_data(r), 4'b1111);
        for (int i = 0; i < 16383; i++) drive(4'b1111, round_data(9), 4'b0000);
        check("sat_below", 64'(drop_count), 64'(65532));
        drive(4'b1111, round_data(9), 4'b0000);
        check("sat_hit", 64'(drop_count), 64'(16'hFFFF));
        drive(4'b1111, round_data(9), 4'b0000);
        check("sat_hold", 64'(drop_count), 64'(16'hFFFF));
        check("sat_ovf", 64'(overflow), 64'(4'b1111));

        // Reset while in WAIT with data still queued.
        serial_busy = 1'b0;
        t = 0;
        while (!serial_send && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("w_strobe_seen", 64'(serial_send), 64'(1));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("w_rst_send", 64'(serial_send), 64'(0));
        check("w_rst_nonce", 64'(golden_nonce), 64'(0));
        check("w_rst_slave", 64'(golden_slave), 64'(0));
        check("w_rst_ovf", 64'(overflow), 64'(0));
        check("w_rst_drops", 64'(drop_count), 64'(0));
        sb.delete();
        st.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("w_quiet_strobes", 64'(st.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
